rib_arbiter: RTL and testbench



---
 rtl/rib_arbiter_pkg.sv | 20 ++
 rtl/rib_rr_pick.sv | 30 +++
 rtl/rib_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_rib_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rib_arbiter_pkg.sv
// Shared definitions for the RIB bus arbiter: bus widths, FSM encodings, constants.
package rib_arbiter_pkg;

  localparam int unsigned MemAddrBus = 32;
  localparam int unsigned MemBus     = 32;
  localparam int unsigned NumMst     = 3;
  localparam int unsigned MstIdxW    = 2;

  localparam logic [MemBus-1:0] ZeroWord    = '0;
  localparam logic [MemBus-1:0] DeadBeef    = 32'hDEADBEEF;
  localparam logic              HoldEnable  = 1'b1;
  localparam logic              HoldDisable = 1'b0;

  typedef enum logic [1:0] {
    RibArbIdle = 2'd0,
    RibArbBusy = 2'd1,
    RibArbResp = 2'd2
  } rib_arb_state_e;

endpackage

// File: rtl/rib_rr_pick.sv
// Combinational round-robin picker: search starts at last_grant+1 (mod 3).
module rib_rr_pick
  import rib_arbiter_pkg::*;
(
  input  logic [NumMst-1:0]  req,
  input  logic [MstIdxW-1:0] last_grant,
  output logic [NumMst-1:0]  grant_oh_c,
  output logic [MstIdxW-1:0] grant_idx_c
);

  logic [MstIdxW-1:0] cand;
  logic               found;

  // First requester in rotated priority order wins.
  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 0; i < int'(NumMst); i++) begin
      cand = MstIdxW'((32'(last_grant) + 32'(i) + 32'd1) % NumMst);
      if (!found && req[cand]) begin
        found            = 1'b1;
        grant_oh_c[cand] = 1'b1;
        grant_idx_c      = cand;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// Three-master round-robin arbiter in front of the RIB bus, one outstanding
// transaction at a time. Optional slave-ack timeout: RIB_ARB_TIMEOUT_EN.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = MemAddrBus,
  parameter int unsigned DATA_W         = MemBus,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_data_i,
  output logic [DATA_W-1:0] m2_data_o,
  output logic              m2_ack_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic              err_o,
  output logic              hold_flag_o
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("rib_arbiter: TIMEOUT_CYCLES must be within 2..255");
  end

  logic [NumMst-1:0]  req_vec, we_vec, pick_oh;
  logic [ADDR_W-1:0]  addr_arr [NumMst];
  logic [DATA_W-1:0]  wdata_arr [NumMst];
  logic [MstIdxW-1:0] pick_idx;

  rib_arb_state_e     state_q, state_d;
  logic [MstIdxW-1:0] grant_q, grant_d, last_q, last_d;
  logic               s_req_q, s_req_d, s_we_q, s_we_d;
  logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
  logic [DATA_W-1:0]  s_data_q, s_data_d;
  logic [NumMst-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]  data_q [NumMst];
  logic [DATA_W-1:0]  data_d [NumMst];
`ifdef RIB_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  assign req_vec      = {m2_req_i, m1_req_i, m0_req_i};
  assign we_vec       = {m2_we_i, m1_we_i, m0_we_i};
  assign addr_arr[0]  = m0_addr_i;
  assign addr_arr[1]  = m1_addr_i;
  assign addr_arr[2]  = m2_addr_i;
  assign wdata_arr[0] = m0_data_i;
  assign wdata_arr[1] = m1_data_i;
  assign wdata_arr[2] = m2_data_i;

  rib_rr_pick u_pick (
    .req         (req_vec),
    .last_grant  (last_q),
    .grant_oh_c  (pick_oh),
    .grant_idx_c (pick_idx)
  );

  // Next-state and next-output logic for IDLE -> BUSY -> RESP.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    s_req_d  = s_req_q;
    s_we_d   = s_we_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    ack_d    = '0;
    data_d   = data_q;
`ifdef RIB_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      RibArbIdle: begin
        if (|req_vec) begin
          for (int i = 0; i < int'(NumMst); i++) begin
            if (pick_oh[i]) begin
              s_we_d   = we_vec[i];
              s_addr_d = addr_arr[i];
              s_data_d = wdata_arr[i];
            end
          end
          s_req_d = 1'b1;
          grant_d = pick_idx;
          last_d  = pick_idx;
          state_d = RibArbBusy;
`ifdef RIB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RibArbBusy: begin
        if (s_ack_i) begin
          for (int i = 0; i < int'(NumMst); i++) begin
            if (grant_q == MstIdxW'(i)) begin
              ack_d[i] = 1'b1;
              if (!s_we_q) data_d[i] = s_data_i;
            end
          end
          s_req_d = 1'b0;
          state_d = RibArbResp;
        end
`ifdef RIB_ARB_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          for (int i = 0; i < int'(NumMst); i++) begin
            if (grant_q == MstIdxW'(i)) begin
              ack_d[i] = 1'b1;
              if (!s_we_q) data_d[i] = DATA_W'(DeadBeef);
            end
          end
          err_d   = 1'b1;
          s_req_d = 1'b0;
          state_d = RibArbResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RibArbResp: state_d = RibArbIdle;
      default:    state_d = RibArbIdle;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RibArbIdle;
      grant_q  <= '0;
      last_q   <= MstIdxW'(2);
      s_req_q  <= 1'b0;
      s_we_q   <= 1'b0;
      s_addr_q <= '0;
      s_data_q <= '0;
      ack_q    <= '0;
      for (int i = 0; i < int'(NumMst); i++) data_q[i] <= '0;
`ifdef RIB_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      s_req_q  <= s_req_d;
      s_we_q   <= s_we_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
`ifdef RIB_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign s_req_o   = s_req_q;
  assign s_we_o    = s_we_q;
  assign s_addr_o  = s_addr_q;
  assign s_data_o  = s_data_q;
  assign m0_ack_o  = ack_q[0];
  assign m1_ack_o  = ack_q[1];
  assign m2_ack_o  = ack_q[2];
  assign m0_data_o = data_q[0];
  assign m1_data_o = data_q[1];
  assign m2_data_o = data_q[2];
`ifdef RIB_ARB_TIMEOUT_EN
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

  // Stall the pipeline while a transaction is in flight or any master is asking.
  assign hold_flag_o = ((state_q != RibArbIdle) || (|req_vec)) ? HoldEnable : HoldDisable;

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: vector table plus multi-cycle corner sequences.
module tb_rib_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_req [3];
  logic        m_we [3];
  logic [31:0] m_addr [3];
  logic [31:0] m_wdata [3];
  wire  [31:0] m_rdata [3];
  wire  [2:0]  m_ack;
  wire         s_req, s_we, err, hold;
  wire  [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = '0;
  logic        s_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rd [3];

  always #5 clk = ~clk;

  rib_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m_req[0]), .m0_we_i(m_we[0]), .m0_addr_i(m_addr[0]), .m0_data_i(m_wdata[0]),
    .m0_data_o(m_rdata[0]), .m0_ack_o(m_ack[0]),
    .m1_req_i(m_req[1]), .m1_we_i(m_we[1]), .m1_addr_i(m_addr[1]), .m1_data_i(m_wdata[1]),
    .m1_data_o(m_rdata[1]), .m1_ack_o(m_ack[1]),
    .m2_req_i(m_req[2]), .m2_we_i(m_we[2]), .m2_addr_i(m_addr[2]), .m2_data_i(m_wdata[2]),
    .m2_data_o(m_rdata[2]), .m2_ack_o(m_ack[2]),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_data_o(s_wdata),
    .s_data_i(s_rdata), .s_ack_i(s_ack), .err_o(err), .hold_flag_o(hold)
  );

  typedef struct {
    logic [2:0]  req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] rdata;
    int          exp_m;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    for (int m = 0; m < 3; m++) begin
      m_req[m] = 1'b0; m_we[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_masters();
    s_ack = 1'b0;
    for (int m = 0; m < 3; m++) exp_rd[m] = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic check_data(input string name);
    for (int m = 0; m < 3; m++) check(name, m_rdata[m], exp_rd[m]);
  endtask

  initial begin
    int budget;
    int ack_cnt [3];
    int order [4];
    logic [31:0] saddr_hold;

    // req, we, addr, wdata, wait, rdata, winner (last_grant evolves 2,0,1,2,1,2,0,2)
    vecs[0] = '{3'b001, 1'b0, 32'h1000_0004, 32'h0,          0, 32'h1234_5678, 0};
    vecs[1] = '{3'b010, 1'b1, 32'h2000_0000, 32'hA5A5_A5A5,  4, 32'hFFFF_0000, 1};
    vecs[2] = '{3'b111, 1'b0, 32'h3000_0008, 32'h0,          1, 32'hCAFE_F00D, 2};
    vecs[3] = '{3'b110, 1'b0, 32'h3000_0010, 32'h0,          0, 32'h1111_2222, 1};
    vecs[4] = '{3'b101, 1'b1, 32'h5000_0020, 32'h0BAD_CAFE,  2, 32'h7777_7777, 2};
    vecs[5] = '{3'b011, 1'b0, 32'h6000_0040, 32'h0,          3, 32'h3333_4444, 0};
    vecs[6] = '{3'b101, 1'b0, 32'h7000_0080, 32'h0,          0, 32'h5555_6666, 2};

    clear_masters();
    #1;
    check("reset_s_req", 32'(s_req), 32'd0);
    check("reset_ack", 32'(m_ack), 32'd0);
    do_reset();
    check("reset_s_we", 32'(s_we), 32'd0);
    check("reset_s_addr", s_addr, 32'd0);
    check("reset_s_data", s_wdata, 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_hold", 32'(hold), 32'd0);
    check_data("reset_mdata");

    // Table: one transaction per vector, non-winners carry distinguishable payloads.
    for (int v = 0; v < 7; v++) begin
      for (int m = 0; m < 3; m++) begin
        m_req[m]   = vecs[v].req[m];
        m_we[m]    = (m == vecs[v].exp_m) ? vecs[v].we : ~vecs[v].we;
        m_addr[m]  = (m == vecs[v].exp_m) ? vecs[v].addr : vecs[v].addr ^ 32'h0F00_0000;
        m_wdata[m] = (m == vecs[v].exp_m) ? vecs[v].wdata : ~vecs[v].wdata;
      end
      #1;
      check("v_hold_req", 32'(hold), 32'd1);
      step();
      check("v_s_req", 32'(s_req), 32'd1);
      check("v_s_we", 32'(s_we), 32'(vecs[v].we));
      check("v_s_addr", s_addr, vecs[v].addr);
      check("v_s_data", s_wdata, vecs[v].wdata);
      for (int w = 0; w < vecs[v].wait_n; w++) begin
        step();
        check("v_wait_s_req", 32'(s_req), 32'd1);
        check("v_wait_s_addr", s_addr, vecs[v].addr);
        check("v_wait_s_we", 32'(s_we), 32'(vecs[v].we));
        check("v_wait_ack", 32'(m_ack), 32'd0);
        check("v_wait_hold", 32'(hold), 32'd1);
      end
      s_ack = 1'b1;
      s_rdata = vecs[v].rdata;
      step();
      s_ack = 1'b0;
      s_rdata = 32'hDEAD_0000;
      if (!vecs[v].we) exp_rd[vecs[v].exp_m] = vecs[v].rdata;
      check("v_ack", 32'(m_ack), 32'd1 << vecs[v].exp_m);
      check("v_s_req_drop", 32'(s_req), 32'd0);
      check("v_err", 32'(err), 32'd0);
      check("v_hold_resp", 32'(hold), 32'd1);
      check_data("v_mdata");
      clear_masters();
      step();
      check("v_ack_clear", 32'(m_ack), 32'd0);
      check("v_hold_idle", 32'(hold), 32'd0);
      check_data("v_mdata_hold");
    end

    // Continuous requests from all three after reset: order m0, m1, m2, m0.
    do_reset();
    order = '{0, 1, 2, 0};
    for (int m = 0; m < 3; m++) begin
      ack_cnt[m] = 0;
      m_req[m] = 1'b1; m_we[m] = 1'b0;
      m_addr[m] = 32'h4000_0000 + 32'(m) * 32'h100;
    end
    for (int t = 0; t < 4; t++) begin
      budget = 0;
      while (!s_req && budget < 8) begin
        step();
        budget++;
      end
      check("rr_s_req", 32'(s_req), 32'd1);
      check("rr_s_addr", s_addr, 32'h4000_0000 + 32'(order[t]) * 32'h100);
      s_ack = 1'b1;
      s_rdata = 32'hA000_0000 + 32'(t);
      step();
      s_ack = 1'b0;
      exp_rd[order[t]] = 32'hA000_0000 + 32'(t);
      check("rr_ack", 32'(m_ack), 32'd1 << order[t]);
      check_data("rr_mdata");
      for (int m = 0; m < 3; m++) ack_cnt[m] += int'(m_ack[m]);
      if (t == 2) begin
        for (int m = 0; m < 3; m++) check("rr_ack_count", 32'(ack_cnt[m]), 32'd1);
      end
      step();
    end
    clear_masters();
    step();

    // Reset during the second BUSY cycle: transaction lost, m2 then served first.
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = 32'h8000_0000;
    step();
    check("rst_busy1", 32'(s_req), 32'd1);
    step();
    saddr_hold = s_addr;
    check("rst_busy2_addr", saddr_hold, 32'h8000_0000);
    rst = 1'b0;
    m_req[0] = 1'b0;
    m_req[2] = 1'b1; m_addr[2] = 32'h9000_0000; m_wdata[2] = 32'h0;
    #1;
    check("rst_async_s_req", 32'(s_req), 32'd0);
    check("rst_async_addr", s_addr, 32'd0);
    step();
    check("rst_no_ack", 32'(m_ack), 32'd0);
    rst = 1'b1;
    step();
    check("rst_m2_s_req", 32'(s_req), 32'd1);
    check("rst_m2_addr", s_addr, 32'h9000_0000);
    s_ack = 1'b1;
    s_rdata = 32'h0000_00C3;
    step();
    s_ack = 1'b0;
    check("rst_m2_ack", 32'(m_ack), 32'b100);
    check("rst_m2_data", m_rdata[2], 32'h0000_00C3);
    clear_masters();
    step();

`ifdef RIB_ARB_TIMEOUT_EN
    // Slave never acks: timeout after 16 BUSY cycles with err and DEADBEEF.
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = 32'h1000_0000;
    step();
    check("to_s_req", 32'(s_req), 32'd1);
    for (int c = 1; c < 16; c++) begin
      step();
      check("to_busy_req", 32'(s_req), 32'd1);
      check("to_busy_ack", 32'(m_ack), 32'd0);
      check("to_busy_err", 32'(err), 32'd0);
    end
    step();
    check("to_ack", 32'(m_ack), 32'b001);
    check("to_err", 32'(err), 32'd1);
    check("to_s_req_drop", 32'(s_req), 32'd0);
    check("to_data", m_rdata[0], 32'hDEADBEEF);
    clear_masters();
    step();
    check("to_err_clear", 32'(err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
